sdio_init_seq: RTL and testbench
================================

Name: sdio_init_seq

Overview:
- Host-side card-identification sequencer. Drives the command-wire front end (command request/response handshake) through the SD power-up sequence: CMD0, CMD8, ACMD41 polling, CMD2, CMD3, CMD7, and an optional ACMD6 bus-width switch.
- Sits between the control registers (start, status) and the host command engine.
- On completion it publishes the card's RCA, its capacity mode, and the selected bus width for the data path.

Parameters:
- MAX_POLLS, 1000: maximum number of ACMD41 attempts before declaring a power-up timeout.
- LGPOLLDLY, 10: log2 of the idle clocks between ACMD41 attempts.
- OPT_HCS, 1'b1: request high capacity (ACMD41 arg[30]).
- OPT_WIDE, 1'b1: issue ACMD6 to select a 4-bit bus.
- VHS_PATTERN, 12'h1AA: CMD8 voltage and check-pattern argument.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_start  in  1  single-cycle request to begin the sequence.
- o_busy  out  1  sequence in progress.
- o_done  out  1  one-cycle pulse on success.
- o_err  out  1  one-cycle pulse on failure.
- o_err_code  out  4  error code; held until the next i_start.
- o_cmd_valid  out  1  command request.
- i_cmd_ready  in  1  command engine accepts the request.
- o_cmd_id  out  6  command index.
- o_cmd_arg  out  32  command argument.
- o_rsp_type  out  2  expected response: 0 none, 1 R1/R6/R7, 2 R2, 3 R3.
- i_rsp_valid  in  1  response received, or command sent when type is none.
- i_rsp_crc_err  in  1  qualifies i_rsp_valid.
- i_rsp_timeout  in  1  no response arrived.
- i_rsp_arg  in  32  response payload bits [39:8].
- o_rca  out  16  relative card address.
- o_ccs  out  1  card is high capacity.
- o_v2  out  1  card answered CMD8.
- o_wide  out  1  4-bit bus selected.

Behaviour:
- Reset values:
  - All outputs 0.
  - Internal state IDLE.
  - Async reset mid-sequence returns to IDLE immediately; no command is left requested.
- States: IDLE, CMD0, CMD8, A41_55, A41, POLLWAIT, CMD2, CMD3, CMD7, A6_55, A6, DONE, ERR.
  - Each command state has an ISSUE phase and a WAIT phase.
- ISSUE phase:
  - o_cmd_valid=1 with o_cmd_id, o_cmd_arg and o_rsp_type stable until i_cmd_valid&&i_cmd_ready.
  - The cycle after acceptance, o_cmd_valid=0 and the state enters WAIT.
- WAIT phase: exactly one of i_rsp_valid or i_rsp_timeout is taken per command.
  - If both are asserted in the same cycle, i_rsp_valid wins.
  - If i_rsp_crc_err is asserted with i_rsp_valid in any state except A41, it is treated as an error.
- IDLE:
  - i_start clears o_err_code and moves to CMD0.
  - o_busy=1 in every state except IDLE.
  - i_start while busy is ignored.
- CMD0: id 0, arg 0, type none. On i_rsp_valid go to CMD8.
- CMD8: id 8, arg {20'h0, VHS_PATTERN}, type 1.
  - Response with arg[11:0]==VHS_PATTERN: o_v2=1, go to A41_55.
  - Response with a mismatched pattern: ERR, code 2.
  - Timeout: o_v2=0 (v1 card), go to A41_55.
- A41_55: id 55, arg 0, type 1. Response goes to A41; timeout is ERR, code 3.
- A41: id 41, type 3.
  - arg = {1'b0, OPT_HCS&&o_v2, 6'h0, 16'hFF80, 8'h0}.
  - CRC error is ignored, since R3 carries no CRC.
  - If arg[31]=1: o_ccs<=arg[30]&&o_v2, go to CMD2.
  - Otherwise increment the poll counter and go to POLLWAIT.
  - Timeout: ERR, code 4.
- POLLWAIT:
  - Counts 2^LGPOLLDLY clocks, then returns to A41_55.
  - If the poll counter reaches MAX_POLLS: ERR, code 5.
  - The poll counter is $clog2(MAX_POLLS+1) bits wide and saturates.
- CMD2: id 2, arg 0, type 2. Response goes to CMD3; timeout is ERR, code 6.
- CMD3: id 3, arg 0, type 1.
  - Response with arg[31:16]!=0: latch o_rca, go to CMD7.
  - Response with RCA==0: reissue CMD3, up to 3 attempts, then ERR, code 7.
- CMD7: id 7, arg {o_rca, 16'h0}, type 1.
  - Response goes to A6_55 if OPT_WIDE, otherwise DONE.
  - Timeout: ERR, code 8.
- A6_55: id 55, arg {o_rca, 16'h0}, type 1. Response goes to A6; timeout is ERR, code 9.
- A6: id 6, arg 32'h2, type 1.
  - Response: o_wide=1, go to DONE.
  - Timeout: ERR, code 9.
- DONE: pulse o_done for one cycle, then IDLE. The o_rca, o_ccs, o_v2 and o_wide outputs hold.
- ERR:
  - Pulse o_err for one cycle and latch o_err_code.
  - CRC errors use code 1, except in A41.
  - Then IDLE; o_rca, o_ccs and o_wide are cleared.
- Each new i_start clears o_rca, o_ccs, o_v2 and o_wide at the CMD0 transition.

Decomposition:
- Shared package sdio_pkg holds:
  - command index constants (CMD0/2/3/6/7/8/41/55);
  - response-type encodings;
  - error-code constants;
  - the FSM state enumeration.
- One natural sub-module, sdio_poll_timer: the POLLWAIT delay counter plus the saturating poll counter, with start, expired and limit outputs.

Test Plan:
- v2 high-capacity card. Responder echoes CMD8 arg 0x1AA. ACMD41 returns 0x00FF8000 twice, then 0xC0FF8000. CMD3 returns arg 0x12340000. Required: command order 0,8,55,41,55,41,55,41,2,3,7,55,6. o_rca=16'h1234, o_ccs=1, o_v2=1, o_wide=1, one o_done pulse.
- v1 card. CMD8 times out. Required: A41 arg[30]=0, o_v2=0, o_ccs=0 even if the response sets bit 30.
- Power-up timeout. MAX_POLLS=4 and ACMD41 never reports ready. Required: exactly 4 ACMD41 commands, then o_err with code 5.
- CMD8 pattern mismatch. Response arg[11:0]=0x155. Required: o_err, code 2; no CMD55 issued.
- Handshake and CRC. i_cmd_ready is held low for 5 cycles on CMD2. Required: o_cmd_id and o_cmd_arg are stable throughout. A CRC error on the CMD7 response gives o_err, code 1. A CRC error on an A41 response is ignored.
- Reset and restart. i_reset_n is asserted during POLLWAIT. Required: o_busy=0 and o_cmd_valid=0 asynchronously. A following i_start restarts at CMD0 with cleared outputs.

Source files
------------

// File: rtl/sdio_pkg.sv
// Shared constants for the SD card-identification sequencer: command indices,
// response types, error codes and FSM state encodings.
package sdio_pkg;

    localparam logic [5:0] CMD_GO_IDLE      = 6'd0;
    localparam logic [5:0] CMD_ALL_SEND_CID = 6'd2;
    localparam logic [5:0] CMD_SEND_RCA     = 6'd3;
    localparam logic [5:0] CMD_SET_WIDTH    = 6'd6;
    localparam logic [5:0] CMD_SELECT       = 6'd7;
    localparam logic [5:0] CMD_SEND_IF_COND = 6'd8;
    localparam logic [5:0] CMD_SD_OP_COND   = 6'd41;
    localparam logic [5:0] CMD_APP          = 6'd55;

    localparam logic [1:0] RSP_NONE = 2'd0;
    localparam logic [1:0] RSP_R1   = 2'd1;
    localparam logic [1:0] RSP_R2   = 2'd2;
    localparam logic [1:0] RSP_R3   = 2'd3;

    localparam logic [3:0] ERR_NONE    = 4'd0;
    localparam logic [3:0] ERR_CRC     = 4'd1;
    localparam logic [3:0] ERR_PATTERN = 4'd2;
    localparam logic [3:0] ERR_APP41   = 4'd3;
    localparam logic [3:0] ERR_OPCOND  = 4'd4;
    localparam logic [3:0] ERR_POWERUP = 4'd5;
    localparam logic [3:0] ERR_CID     = 4'd6;
    localparam logic [3:0] ERR_RCA     = 4'd7;
    localparam logic [3:0] ERR_SELECT  = 4'd8;
    localparam logic [3:0] ERR_WIDTH   = 4'd9;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_CMD0     = 4'd1;
    localparam logic [3:0] S_CMD8     = 4'd2;
    localparam logic [3:0] S_A41_55   = 4'd3;
    localparam logic [3:0] S_A41      = 4'd4;
    localparam logic [3:0] S_POLLWAIT = 4'd5;
    localparam logic [3:0] S_CMD2     = 4'd6;
    localparam logic [3:0] S_CMD3     = 4'd7;
    localparam logic [3:0] S_CMD7     = 4'd8;
    localparam logic [3:0] S_A6_55    = 4'd9;
    localparam logic [3:0] S_A6       = 4'd10;
    localparam logic [3:0] S_DONE     = 4'd11;
    localparam logic [3:0] S_ERR      = 4'd12;

    // States that own a command issue/wait exchange with the command engine.
    function automatic logic is_cmd_state(input logic [3:0] s);
        return !(s inside {S_IDLE, S_POLLWAIT, S_DONE, S_ERR});
    endfunction

endpackage

// File: rtl/sdio_poll_timer.sv
// ACMD41 retry pacing: a 2^LGPOLLDLY-clock delay plus a saturating count of
// unsuccessful polls, with a limit flag once MAX_POLLS have been made.
module sdio_poll_timer #(
    parameter int MAX_POLLS = 1000,
    parameter int LGPOLLDLY = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic start,
    output logic expired,
    output logic limit
);
    localparam int PW = $clog2(MAX_POLLS + 1);
    localparam logic [PW-1:0] POLL_MAX = PW'(MAX_POLLS);

    logic [LGPOLLDLY-1:0] dly_cnt;
    logic                 running;
    logic [PW-1:0]        poll_cnt;

    assign expired = running && (dly_cnt == '1);
    assign limit   = (poll_cnt >= POLL_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_cnt <= '0;
            running <= 1'b0;
        end else if (clear) begin
            dly_cnt <= '0;
            running <= 1'b0;
        end else if (start) begin
            dly_cnt <= '0;
            running <= 1'b1;
        end else if (running) begin
            dly_cnt <= dly_cnt + LGPOLLDLY'(1);
            if (dly_cnt == '1)
                running <= 1'b0;
        end
    end

    // Each start marks one more failed poll; the count sticks at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            poll_cnt <= '0;
        else if (clear)
            poll_cnt <= '0;
        else if (start && (poll_cnt != POLL_MAX))
            poll_cnt <= poll_cnt + PW'(1);
    end

endmodule

// File: rtl/sdio_init_seq.sv
// Host-side SD card identification sequencer: CMD0, CMD8, ACMD41 polling,
// CMD2, CMD3, CMD7 and optional ACMD6, publishing RCA, capacity and width.
module sdio_init_seq
    import sdio_pkg::*;
#(
    parameter int          MAX_POLLS   = 1000,
    parameter int          LGPOLLDLY   = 10,
    parameter logic        OPT_HCS     = 1'b1,
    parameter logic        OPT_WIDE    = 1'b1,
    parameter logic [11:0] VHS_PATTERN = 12'h1AA
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [3:0]  o_err_code,
    output logic        o_cmd_valid,
    input  logic        i_cmd_ready,
    output logic [5:0]  o_cmd_id,
    output logic [31:0] o_cmd_arg,
    output logic [1:0]  o_rsp_type,
    input  logic        i_rsp_valid,
    input  logic        i_rsp_crc_err,
    input  logic        i_rsp_timeout,
    input  logic [31:0] i_rsp_arg,
    output logic [15:0] o_rca,
    output logic        o_ccs,
    output logic        o_v2,
    output logic        o_wide
);
    logic [3:0] state;
    logic [1:0] rca_tries;
    logic       waiting;
    logic       take_rsp;
    logic       take_to;
    logic       crc_fail;
    logic       poll_clear;
    logic       poll_start;
    logic       poll_expired;
    logic       poll_limit;
    logic       unused_rsp;

    assign unused_rsp = ^i_rsp_arg[15:12];

    // A command state with its request already accepted is in its wait phase.
    assign waiting  = is_cmd_state(state) && !o_cmd_valid;
    assign take_rsp = waiting && i_rsp_valid;
    assign take_to  = waiting && !i_rsp_valid && i_rsp_timeout;
    assign crc_fail = take_rsp && i_rsp_crc_err && (state != S_A41);

    assign poll_clear = (state == S_IDLE) && i_start;
    assign poll_start = (state == S_A41) && take_rsp && !i_rsp_arg[31];

    assign o_busy = (state != S_IDLE);
    assign o_done = (state == S_DONE);
    assign o_err  = (state == S_ERR);

    sdio_poll_timer #(
        .MAX_POLLS (MAX_POLLS),
        .LGPOLLDLY (LGPOLLDLY)
    ) u_poll_timer (
        .clk     (i_clk),
        .rst_n   (i_reset_n),
        .clear   (poll_clear),
        .start   (poll_start),
        .expired (poll_expired),
        .limit   (poll_limit)
    );

    always_comb begin
        o_cmd_id   = CMD_GO_IDLE;
        o_cmd_arg  = 32'h0;
        o_rsp_type = RSP_NONE;
        case (state)
            S_CMD8: begin
                o_cmd_id   = CMD_SEND_IF_COND;
                o_cmd_arg  = {20'h0, VHS_PATTERN};
                o_rsp_type = RSP_R1;
            end
            S_A41_55: begin
                o_cmd_id   = CMD_APP;
                o_rsp_type = RSP_R1;
            end
            S_A41: begin
                o_cmd_id   = CMD_SD_OP_COND;
                o_cmd_arg  = {1'b0, OPT_HCS && o_v2, 6'h0, 16'hFF80, 8'h0};
                o_rsp_type = RSP_R3;
            end
            S_CMD2: begin
                o_cmd_id   = CMD_ALL_SEND_CID;
                o_rsp_type = RSP_R2;
            end
            S_CMD3: begin
                o_cmd_id   = CMD_SEND_RCA;
                o_rsp_type = RSP_R1;
            end
            S_CMD7: begin
                o_cmd_id   = CMD_SELECT;
                o_cmd_arg  = {o_rca, 16'h0};
                o_rsp_type = RSP_R1;
            end
            S_A6_55: begin
                o_cmd_id   = CMD_APP;
                o_cmd_arg  = {o_rca, 16'h0};
                o_rsp_type = RSP_R1;
            end
            S_A6: begin
                o_cmd_id   = CMD_SET_WIDTH;
                o_cmd_arg  = 32'h2;
                o_rsp_type = RSP_R1;
            end
            default: ;
        endcase
    end

    // Every transition into a command state re-arms o_cmd_valid for its issue phase.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= S_IDLE;
            o_cmd_valid <= 1'b0;
            o_err_code  <= ERR_NONE;
            o_rca       <= 16'h0;
            o_ccs       <= 1'b0;
            o_v2        <= 1'b0;
            o_wide      <= 1'b0;
            rca_tries   <= 2'd0;
        end else begin
            if (o_cmd_valid && i_cmd_ready)
                o_cmd_valid <= 1'b0;

            if (crc_fail) begin
                state      <= S_ERR;
                o_err_code <= ERR_CRC;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_start) begin
                            o_err_code  <= ERR_NONE;
                            o_rca       <= 16'h0;
                            o_ccs       <= 1'b0;
                            o_v2        <= 1'b0;
                            o_wide      <= 1'b0;
                            state       <= S_CMD0;
                            o_cmd_valid <= 1'b1;
                        end
                    end
                    S_CMD0: begin
                        if (take_rsp || take_to) begin
                            state       <= S_CMD8;
                            o_cmd_valid <= 1'b1;
                        end
                    end
                    S_CMD8: begin
                        if (take_rsp) begin
                            if (i_rsp_arg[11:0] == VHS_PATTERN) begin
                                o_v2        <= 1'b1;
                                state       <= S_A41_55;
                                o_cmd_valid <= 1'b1;
                            end else begin
                                state      <= S_ERR;
                                o_err_code <= ERR_PATTERN;
                            end
                        end else if (take_to) begin
                            o_v2        <= 1'b0;
                            state       <= S_A41_55;
                            o_cmd_valid <= 1'b1;
                        end
                    end
                    S_A41_55: begin
                        if (take_rsp) begin
                            state       <= S_A41;
                            o_cmd_valid <= 1'b1;
                        end else if (take_to) begin
                            state      <= S_ERR;
                            o_err_code <= ERR_APP41;
                        end
                    end
                    S_A41: begin
                        if (take_rsp) begin
                            if (i_rsp_arg[31]) begin
                                o_ccs       <= i_rsp_arg[30] && o_v2;
                                state       <= S_CMD2;
                                o_cmd_valid <= 1'b1;
                            end else begin
                                state <= S_POLLWAIT;
                            end
                        end else if (take_to) begin
                            state      <= S_ERR;
                            o_err_code <= ERR_OPCOND;
                        end
                    end
                    S_POLLWAIT: begin
                        if (poll_limit) begin
                            state      <= S_ERR;
                            o_err_code <= ERR_POWERUP;
                        end else if (poll_expired) begin
                            state       <= S_A41_55;
                            o_cmd_valid <= 1'b1;
                        end
                    end
                    S_CMD2: begin
                        if (take_rsp) begin
                            rca_tries   <= 2'd0;
                            state       <= S_CMD3;
                            o_cmd_valid <= 1'b1;
                        end else if (take_to) begin
                            state      <= S_ERR;
                            o_err_code <= ERR_CID;
                        end
                    end
                    S_CMD3: begin
                        if (take_rsp && (i_rsp_arg[31:16] != 16'h0)) begin
                            o_rca       <= i_rsp_arg[31:16];
                            state       <= S_CMD7;
                            o_cmd_valid <= 1'b1;
                        end else if (take_rsp && (rca_tries != 2'd2)) begin
                            rca_tries   <= rca_tries + 2'd1;
                            o_cmd_valid <= 1'b1;
                        end else if (take_rsp || take_to) begin
                            state      <= S_ERR;
                            o_err_code <= ERR_RCA;
                        end
                    end
                    S_CMD7: begin
                        if (take_rsp) begin
                            if (OPT_WIDE) begin
                                state       <= S_A6_55;
                                o_cmd_valid <= 1'b1;
                            end else begin
                                state <= S_DONE;
                            end
                        end else if (take_to) begin
                            state      <= S_ERR;
                            o_err_code <= ERR_SELECT;
                        end
                    end
                    S_A6_55: begin
                        if (take_rsp) begin
                            state       <= S_A6;
                            o_cmd_valid <= 1'b1;
                        end else if (take_to) begin
                            state      <= S_ERR;
                            o_err_code <= ERR_WIDTH;
                        end
                    end
                    S_A6: begin
                        if (take_rsp) begin
                            o_wide <= 1'b1;
                            state  <= S_DONE;
                        end else if (take_to) begin
                            state      <= S_ERR;
                            o_err_code <= ERR_WIDTH;
                        end
                    end
                    S_DONE: state <= S_IDLE;
                    S_ERR: begin
                        o_rca  <= 16'h0;
                        o_ccs  <= 1'b0;
                        o_wide <= 1'b0;
                        state  <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdio_init_seq.sv
// Bench for sdio_init_seq: a behavioural card responder logs issued commands,
// and each scenario compares that log and the published results to its own expectations.
module tb_sdio_init_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic [3:0]  err_code;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [5:0]  cmd_id;
    logic [31:0] cmd_arg;
    logic [1:0]  rsp_type;
    logic        rsp_valid = 1'b0;
    logic        rsp_crc_err = 1'b0;
    logic        rsp_timeout = 1'b0;
    logic [31:0] rsp_arg = 32'h0;
    logic [15:0] rca;
    logic        ccs, v2, wide;

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];
    int obs_q[$];

    int          cmd8_mode = 0;
    int          a41_fail_left = 0;
    int          a41_count = 0;
    bit          crc_a41 = 1'b0;
    bit          crc_cmd7 = 1'b0;
    bit          stall_cmd2 = 1'b0;
    logic [31:0] cmd3_rsp = 32'h12340000;
    logic [31:0] a41_ready_arg = 32'hC0FF8000;
    logic [31:0] last_a41_arg = 32'h0;
    logic [31:0] last_cmd7_arg = 32'h0;
    logic [31:0] last_a6_arg = 32'h0;
    int          done_cnt = 0;

    sdio_init_seq #(
        .MAX_POLLS   (4),
        .LGPOLLDLY   (3),
        .OPT_HCS     (1'b1),
        .OPT_WIDE    (1'b1),
        .VHS_PATTERN (12'h1AA)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_start       (start),
        .o_busy        (busy),
        .o_done        (done),
        .o_err         (err),
        .o_err_code    (err_code),
        .o_cmd_valid   (cmd_valid),
        .i_cmd_ready   (cmd_ready),
        .o_cmd_id      (cmd_id),
        .o_cmd_arg     (cmd_arg),
        .o_rsp_type    (rsp_type),
        .i_rsp_valid   (rsp_valid),
        .i_rsp_crc_err (rsp_crc_err),
        .i_rsp_timeout (rsp_timeout),
        .i_rsp_arg     (rsp_arg),
        .o_rca         (rca),
        .o_ccs         (ccs),
        .o_v2          (v2),
        .o_wide        (wide)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    // Behavioural card: accepts each request, logs it and answers per configuration.
    initial begin : responder
        logic [5:0]  cur_id;
        logic [31:0] cur_arg;
        forever begin
            @(negedge clk);
            if (rst_n && cmd_valid) begin
                cur_id  = cmd_id;
                cur_arg = cmd_arg;
                obs_q.push_back(int'(cur_id));
                if (cur_id == 6'd2 && stall_cmd2)
                    repeat (5) @(negedge clk);
                cmd_ready = 1'b1;
                @(negedge clk);
                cmd_ready = 1'b0;
                case (cur_id)
                    6'd0: rsp_valid = 1'b1;
                    6'd8: begin
                        if (cmd8_mode == 0) begin
                            rsp_valid = 1'b1;
                            rsp_arg   = {20'h0, 12'h1AA};
                        end else if (cmd8_mode == 1) begin
                            rsp_valid = 1'b1;
                            rsp_arg   = 32'h00000155;
                        end else begin
                            rsp_timeout = 1'b1;
                        end
                    end
                    6'd55: begin
                        rsp_valid = 1'b1;
                        rsp_arg   = 32'h00000120;
                    end
                    6'd41: begin
                        last_a41_arg = cur_arg;
                        a41_count++;
                        rsp_valid = 1'b1;
                        if (a41_fail_left > 0) begin
                            rsp_arg = 32'h00FF8000;
                            a41_fail_left--;
                        end else begin
                            rsp_arg = a41_ready_arg;
                        end
                        rsp_crc_err = crc_a41 && (a41_count == 1);
                    end
                    6'd2: begin
                        rsp_valid = 1'b1;
                        rsp_arg   = 32'hDEADBEEF;
                    end
                    6'd3: begin
                        rsp_valid = 1'b1;
                        rsp_arg   = cmd3_rsp;
                    end
                    6'd7: begin
                        last_cmd7_arg = cur_arg;
                        rsp_valid     = 1'b1;
                        rsp_crc_err   = crc_cmd7;
                    end
                    6'd6: begin
                        last_a6_arg = cur_arg;
                        rsp_valid   = 1'b1;
                    end
                    default: rsp_timeout = 1'b1;
                endcase
                @(negedge clk);
                rsp_valid   = 1'b0;
                rsp_crc_err = 1'b0;
                rsp_timeout = 1'b0;
                rsp_arg     = 32'h0;
            end
        end
    end

    task automatic config_card(input int mode8, input int fails, input bit c41, input bit c7, input bit stall);
        cmd8_mode     = mode8;
        a41_fail_left = fails;
        a41_count     = 0;
        crc_a41       = c41;
        crc_cmd7      = c7;
        stall_cmd2    = stall;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(output bit saw_done, output bit saw_err);
        saw_done = 1'b0;
        saw_err  = 1'b0;
        for (int i = 0; i < 4000 && !saw_done && !saw_err; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
            if (err) saw_err = 1'b1;
        end
        if (!saw_done && !saw_err) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL end_timeout: got no done/err, expected one within 4000 cycles");
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (cmd_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cmd_valid: got %b expected 0", cmd_valid); end
        vectors++; if ({done, err, err_code} !== 6'h0) begin miscompares++; $display("[TB] FAIL reset_status: got %h expected 0", {done, err, err_code}); end
        vectors++; if ({cmd_id, cmd_arg, rsp_type} !== 40'h0) begin miscompares++; $display("[TB] FAIL reset_cmd: got %h expected 0", {cmd_id, cmd_arg, rsp_type}); end
        vectors++; if ({rca, ccs, v2, wide} !== 19'h0) begin miscompares++; $display("[TB] FAIL reset_results: got %h expected 0", {rca, ccs, v2, wide}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_v2_card();
        bit d, e;
        int base, o;
        config_card(0, 2, 1'b0, 1'b0, 1'b0);
        exp_q = '{0, 8, 55, 41, 55, 41, 55, 41, 2, 3, 7, 55, 6};
        base = done_cnt;
        pulse_start();
        wait_end(d, e);
        while (exp_q.size() > 0) begin
            vectors++;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            if (o !== exp_q[0]) begin miscompares++; $display("[TB] FAIL v2_order: got %0d expected %0d", o, exp_q[0]); end
            void'(exp_q.pop_front());
        end
        vectors++; if (obs_q.size() != 0) begin miscompares++; $display("[TB] FAIL v2_extra_cmds: got %0d expected 0", obs_q.size()); end
        vectors++; if (!d || e) begin miscompares++; $display("[TB] FAIL v2_outcome: got done=%b err=%b expected done=1 err=0", d, e); end
        vectors++; if (rca !== 16'h1234) begin miscompares++; $display("[TB] FAIL v2_rca: got %h expected 1234", rca); end
        vectors++; if ({ccs, v2, wide} !== 3'b111) begin miscompares++; $display("[TB] FAIL v2_flags: got %b expected 111", {ccs, v2, wide}); end
        vectors++; if (last_a41_arg !== 32'h40FF8000) begin miscompares++; $display("[TB] FAIL v2_a41_arg: got %h expected 40ff8000", last_a41_arg); end
        vectors++; if (last_cmd7_arg !== 32'h12340000) begin miscompares++; $display("[TB] FAIL v2_cmd7_arg: got %h expected 12340000", last_cmd7_arg); end
        vectors++; if (last_a6_arg !== 32'h2) begin miscompares++; $display("[TB] FAIL v2_a6_arg: got %h expected 2", last_a6_arg); end
        vectors++; if (done_cnt - base != 1) begin miscompares++; $display("[TB] FAIL v2_done_pulses: got %0d expected 1", done_cnt - base); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL v2_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_pattern_mismatch();
        bit d, e;
        int o;
        config_card(1, 0, 1'b0, 1'b0, 1'b0);
        exp_q = '{0, 8};
        pulse_start();
        wait_end(d, e);
        while (exp_q.size() > 0) begin
            vectors++;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            if (o !== exp_q[0]) begin miscompares++; $display("[TB] FAIL mismatch_order: got %0d expected %0d", o, exp_q[0]); end
            void'(exp_q.pop_front());
        end
        vectors++; if (obs_q.size() != 0) begin miscompares++; $display("[TB] FAIL mismatch_extra_cmds: got %0d expected 0", obs_q.size()); end
        vectors++; if (d || !e) begin miscompares++; $display("[TB] FAIL mismatch_outcome: got done=%b err=%b expected done=0 err=1", d, e); end
        repeat (10) @(negedge clk);
        vectors++; if (err_code !== 4'd2) begin miscompares++; $display("[TB] FAIL mismatch_code_held: got %0d expected 2", err_code); end
    endtask

    task automatic test_v1_card();
        bit d, e;
        int o;
        config_card(2, 0, 1'b0, 1'b0, 1'b0);
        exp_q = '{0, 8, 55, 41, 2, 3, 7, 55, 6};
        pulse_start();
        @(negedge clk);
        vectors++; if (err_code !== 4'd0) begin miscompares++; $display("[TB] FAIL v1_code_cleared: got %0d expected 0", err_code); end
        wait_end(d, e);
        while (exp_q.size() > 0) begin
            vectors++;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            if (o !== exp_q[0]) begin miscompares++; $display("[TB] FAIL v1_order: got %0d expected %0d", o, exp_q[0]); end
            void'(exp_q.pop_front());
        end
        vectors++; if (!d || e) begin miscompares++; $display("[TB] FAIL v1_outcome: got done=%b err=%b expected done=1 err=0", d, e); end
        vectors++; if (last_a41_arg !== 32'h00FF8000) begin miscompares++; $display("[TB] FAIL v1_a41_arg: got %h expected 00ff8000", last_a41_arg); end
        vectors++; if ({ccs, v2, wide} !== 3'b001) begin miscompares++; $display("[TB] FAIL v1_flags: got %b expected 001", {ccs, v2, wide}); end
    endtask

    task automatic test_powerup_timeout();
        bit d, e;
        int o;
        config_card(0, 100, 1'b0, 1'b0, 1'b0);
        exp_q = '{0, 8, 55, 41, 55, 41, 55, 41, 55, 41};
        pulse_start();
        wait_end(d, e);
        while (exp_q.size() > 0) begin
            vectors++;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            if (o !== exp_q[0]) begin miscompares++; $display("[TB] FAIL timeout_order: got %0d expected %0d", o, exp_q[0]); end
            void'(exp_q.pop_front());
        end
        vectors++; if (obs_q.size() != 0) begin miscompares++; $display("[TB] FAIL timeout_extra_cmds: got %0d expected 0", obs_q.size()); end
        vectors++; if (a41_count != 4) begin miscompares++; $display("[TB] FAIL timeout_a41_count: got %0d expected 4", a41_count); end
        vectors++; if (d || !e || err_code !== 4'd5) begin miscompares++; $display("[TB] FAIL timeout_code: got err=%b code=%0d expected err=1 code=5", e, err_code); end
    endtask

    task automatic test_handshake_crc();
        bit d, e;
        int o;
        config_card(0, 1, 1'b1, 1'b1, 1'b1);
        exp_q = '{0, 8, 55, 41, 55, 41, 2, 3, 7};
        pulse_start();
        for (int i = 0; i < 2000 && !(cmd_valid && cmd_id == 6'd2); i++) @(negedge clk);
        vectors++;
        if (!(cmd_valid && cmd_id == 6'd2)) begin
            miscompares++;
            $display("[TB] FAIL crc_cmd2_seen: got id %0d valid %b expected CMD2 request", cmd_id, cmd_valid);
        end
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if ({cmd_valid, cmd_id, cmd_arg, rsp_type} !== {1'b1, 6'd2, 32'h0, 2'd2}) begin
                miscompares++;
                $display("[TB] FAIL cmd2_stable: got %h expected %h", {cmd_valid, cmd_id, cmd_arg, rsp_type}, {1'b1, 6'd2, 32'h0, 2'd2});
            end
            @(negedge clk);
        end
        wait_end(d, e);
        while (exp_q.size() > 0) begin
            vectors++;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            if (o !== exp_q[0]) begin miscompares++; $display("[TB] FAIL crc_order: got %0d expected %0d", o, exp_q[0]); end
            void'(exp_q.pop_front());
        end
        vectors++; if (obs_q.size() != 0) begin miscompares++; $display("[TB] FAIL crc_extra_cmds: got %0d expected 0", obs_q.size()); end
        vectors++; if (d || !e || err_code !== 4'd1) begin miscompares++; $display("[TB] FAIL crc_code: got err=%b code=%0d expected err=1 code=1", e, err_code); end
        vectors++; if ({rca, ccs, wide} !== 18'h0) begin miscompares++; $display("[TB] FAIL crc_cleared: got %h expected 0", {rca, ccs, wide}); end
    endtask

    task automatic test_reset_restart();
        bit d, e;
        int o;
        config_card(0, 100, 1'b0, 1'b0, 1'b0);
        pulse_start();
        for (int i = 0; i < 500 && a41_count < 1; i++) @(negedge clk);
        vectors++; if (a41_count < 1) begin miscompares++; $display("[TB] FAIL rst_reach_poll: got %0d ACMD41 expected 1", a41_count); end
        repeat (2) @(negedge clk);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_busy_before: got %b expected 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if ({busy, cmd_valid} !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_async: got busy/valid %b expected 00", {busy, cmd_valid}); end
        vectors++; if (v2 !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_v2: got %b expected 0", v2); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        config_card(0, 2, 1'b0, 1'b0, 1'b0);
        exp_q = '{0, 8, 55, 41, 55, 41, 55, 41, 2, 3, 7, 55, 6};
        pulse_start();
        wait_end(d, e);
        while (exp_q.size() > 0) begin
            vectors++;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            if (o !== exp_q[0]) begin miscompares++; $display("[TB] FAIL restart_order: got %0d expected %0d", o, exp_q[0]); end
            void'(exp_q.pop_front());
        end
        vectors++; if (!d || rca !== 16'h1234 || {ccs, v2, wide} !== 3'b111) begin miscompares++; $display("[TB] FAIL restart_results: got done=%b rca=%h flags=%b expected 1/1234/111", d, rca, {ccs, v2, wide}); end
    endtask

    initial begin
        test_reset();
        test_v2_card();
        test_pattern_mismatch();
        test_v1_card();
        test_powerup_timeout();
        test_handshake_crc();
        test_reset_restart();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
